mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameters: none; all widths come from shared package constants.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 resetn  in  1  reset is asynchronous and active-low.
REQ-004 es_to_ms_valid  in  1  EX stage holds a valid instruction for MEM.
REQ-005 es_to_ms_bus  in  74  {res_from_mem, rf_we, rf_waddr[4:0], alu_result[31:0], mem_op[2:0], pc[31:0]}, MSB first.
REQ-006 ms_allowin  out  1  MEM accepts a new instruction this cycle.
REQ-007 data_sram_data_ok  in  1  load data valid this cycle, one pulse per load request issued by EX.
REQ-008 data_sram_rdata  in  32  load data, sampled only when data_ok=1.
REQ-009 ws_allowin  in  1  WB stage accepts an instruction.
REQ-010 ms_to_ws_valid  out  1  MEM presents a finished instruction to WB.
REQ-011 ms_to_ws_bus  out  70  {rf_we, rf_waddr[4:0], final_result[31:0], pc[31:0]}.
REQ-012 ms_rf_collect  out  39  {res_from_mem&ms_valid, rf_we&ms_valid, rf_waddr, final_result}, for ID hazard/forwarding.

Function
REQ-013 Stage latch shall load es_to_ms_bus when es_to_ms_valid & ms_allowin; ms_valid <= es_to_ms_valid whenever ms_allowin.
REQ-014 ms_allowin shall equal ~ms_valid | (ms_ready_go & ws_allowin); ms_to_ws_valid shall equal ms_valid & ms_ready_go.
REQ-015 FSM states: IDLE (no load pending), WAIT (valid load, data not yet returned), HOLD (load data captured, WB stalled).
REQ-016 IDLE->WAIT when a load enters the latch; WAIT->IDLE when data_ok & ws_allowin; WAIT->HOLD when data_ok & ~ws_allowin; HOLD->IDLE when ws_allowin; on exit to IDLE, a simultaneously accepted new load enters WAIT directly.
REQ-017 ms_ready_go shall be 1 for non-loads, data_ok in WAIT, 1 in HOLD.
REQ-018 In WAIT with data_ok, rdata shall be used combinationally; on WAIT->HOLD it shall be captured into a 32-bit buffer used while in HOLD.
REQ-019 Load extension by mem_op and alu_result[1:0]: 000 ld.w word; 001 ld.b sign-extended byte; 010 ld.h sign-extended half at addr[1]; 011 ld.bu zero-extended byte; 100 ld.hu zero-extended half; other codes treated as ld.w.
REQ-020 final_result shall be extended load data when res_from_mem, else alu_result.
REQ-021 Alignment is guaranteed by EX; MEM performs no alignment check.
REQ-022 data_ok while not in WAIT shall be ignored (no state or data change).
REQ-023 Zero-bubble throughput: back-to-back non-loads, and loads with same-cycle data_ok, shall advance one per cycle when ws_allowin=1.

Reset
REQ-024 On resetn=0, immediately: ms_valid=0, state=IDLE, data buffer=0, latched bus=0; thus ms_to_ws_valid=0, ms_allowin=1, ms_rf_collect=0.
REQ-025 Reset asserted in WAIT or HOLD shall discard the pending load; a late data_ok after reset release is ignored per REQ-022.

Structure
REQ-026 Shared package holds bus width constants (ES_TO_MS=74, MS_TO_WS=70, RF_COLLECT=39), mem_op encodings, and the FSM state enum.
REQ-027 Load extension logic shall be one combinational sub-module, load_ext (inputs mem_op, addr[1:0], rdata; output 32-bit value).

Verification
REQ-028 ALU op rf_we=1 waddr=5 result=0x0000_1234, ws_allowin=1 -> next cycle ms_to_ws_valid=1, final_result=0x0000_1234.
REQ-029 ld.b addr low=2'b11, rdata=0x80FF_0000, data_ok same cycle -> final_result=0xFFFF_FF80, no stall.
REQ-030 ld.hu addr low=2'b10, data_ok 3 cycles late -> ms_allowin=0 for 3 cycles, then final_result=0x0000_80FF.
REQ-031 ld.w data_ok=1 with ws_allowin=0 for 2 cycles, rdata then changes to 0xDEAD_BEEF -> HOLD keeps original data, delivered when ws_allowin=1.
REQ-032 resetn pulsed low in WAIT, then stray data_ok -> ms_valid stays 0, state IDLE, no output.
REQ-033 Load followed by ALU op, data_ok on second cycle, ws_allowin=1 -> ALU op accepted same cycle the load leaves; both reach WB in order.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared constants for the MEM pipeline stage.
// Bus widths, load op encodings and the load-wait FSM states.
package mem_stage_pkg;

  localparam int ES_TO_MS   = 74;
  localparam int MS_TO_WS   = 70;
  localparam int RF_COLLECT = 39;

  localparam logic [2:0] MOP_LD_W  = 3'b000;
  localparam logic [2:0] MOP_LD_B  = 3'b001;
  localparam logic [2:0] MOP_LD_H  = 3'b010;
  localparam logic [2:0] MOP_LD_BU = 3'b011;
  localparam logic [2:0] MOP_LD_HU = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } ms_state_e;

endpackage

// File: rtl/mem_stage_load_ext.sv
// load_ext: picks and extends the loaded byte/half/word.
// In: mem_op[2:0], addr[1:0], rdata[31:0]; out: res[31:0].
module load_ext
  import mem_stage_pkg::*;
(
  input  logic [2:0]  mem_op,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] res
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    unique case (addr)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = addr[1] ? rdata[31:16] : rdata[15:0];
    unique case (1'b1)
      mem_op == MOP_LD_B:  res = {{24{b[7]}}, b};
      mem_op == MOP_LD_H:  res = {{16{h[15]}}, h};
      mem_op == MOP_LD_BU: res = {24'd0, b};
      mem_op == MOP_LD_HU: res = {16'd0, h};
      default:             res = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage, waits for load data and forwards to WB.
// Ports: clk, resetn, EX handshake/bus, data_sram return, WB handshake/bus, ID collect.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  es_to_ms_valid,
  input  logic [ES_TO_MS-1:0]   es_to_ms_bus,
  output logic                  ms_allowin,
  input  logic                  data_sram_data_ok,
  input  logic [31:0]           data_sram_rdata,
  input  logic                  ws_allowin,
  output logic                  ms_to_ws_valid,
  output logic [MS_TO_WS-1:0]   ms_to_ws_bus,
  output logic [RF_COLLECT-1:0] ms_rf_collect
);

  logic                ms_valid;
  logic [ES_TO_MS-1:0] ms_bus;
  ms_state_e           state;
  ms_state_e           state_nx;
  logic [31:0]         ld_buf;

  logic        res_from_mem;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] alu_result;
  logic [2:0]  mem_op;
  logic [31:0] pc;

  assign {res_from_mem, rf_we, rf_waddr,
          alu_result, mem_op, pc} = ms_bus;

  logic        ms_ready_go;
  logic        accept;
  logic        ld_accept;
  logic [31:0] ld_src;
  logic [31:0] ld_val;
  logic [31:0] final_result;

  assign ms_ready_go = ~res_from_mem
                     | (state == ST_HOLD)
                     | ((state == ST_WAIT) & data_sram_data_ok);

  assign ms_allowin     = ~ms_valid | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid & ms_ready_go;

  assign accept    = es_to_ms_valid & ms_allowin;
  assign ld_accept = accept & es_to_ms_bus[ES_TO_MS-1];

  // Buffered data only once WB has stalled a returned load.
  assign ld_src = (state == ST_HOLD) ? ld_buf : data_sram_rdata;

  load_ext u_ext (
    .mem_op (mem_op),
    .addr   (alu_result[1:0]),
    .rdata  (ld_src),
    .res    (ld_val)
  );

  assign final_result = res_from_mem ? ld_val : alu_result;

  assign ms_to_ws_bus  = {rf_we, rf_waddr, final_result, pc};
  assign ms_rf_collect = {res_from_mem & ms_valid, rf_we & ms_valid,
                          rf_waddr, final_result};

  // A newly accepted load overrides the exit of the old one.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_WAIT: if (data_sram_data_ok)
                 state_nx = ws_allowin ? ST_IDLE : ST_HOLD;
      ST_HOLD: if (ws_allowin) state_nx = ST_IDLE;
      default: ;
    endcase
    if (ld_accept) state_nx = ST_WAIT;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid <= 1'b0;
      ms_bus   <= '0;
      state    <= ST_IDLE;
      ld_buf   <= '0;
    end else begin
      state <= state_nx;
      if (ms_allowin) ms_valid <= es_to_ms_valid;
      if (accept) ms_bus <= es_to_ms_bus;
      if ((state == ST_WAIT) & data_sram_data_ok & ~ws_allowin)
        ld_buf <= data_sram_rdata;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage.
// Vector table, corner sequences and a randomized transaction model.
module tb_mem_stage;

  logic        clk;
  logic        resetn;
  logic        es_to_ms_valid;
  logic [73:0] es_to_ms_bus;
  logic        ms_allowin;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        ws_allowin;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic [38:0] ms_rf_collect;

  int errors = 0;
  int checks = 0;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_allowin        (ms_allowin),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ws_allowin        (ws_allowin),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ms_rf_collect     (ms_rf_collect)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic [2:0]  op;
    logic [1:0]  addr;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(string nm, logic [73:0] act, logic [73:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [73:0] mk_bus(logic ld, logic we,
      logic [4:0] wa, logic [31:0] alu, logic [2:0] op, logic [31:0] pc);
    return {ld, we, wa, alu, op, pc};
  endfunction

  function automatic logic [31:0] ref_ext(logic [2:0] op,
      logic [1:0] a, logic [31:0] d);
    int unsigned b, h;
    b = (d >> (8 * a)) & 32'hFF;
    h = (d >> (16 * a[1])) & 32'hFFFF;
    case (op)
      3'd1:    return (b >= 128) ? b - 256 : b;
      3'd2:    return (h >= 32768) ? h - 65536 : h;
      3'd3:    return b;
      3'd4:    return h;
      default: return d;
    endcase
  endfunction

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    es_to_ms_valid    = 1'b0;
    es_to_ms_bus      = '0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    ws_allowin        = 1'b1;
  endtask

  // model of the single MEM slot
  logic        m_valid;
  logic [73:0] m_bus;
  logic        m_got;
  logic [31:0] m_data;

  task automatic model_step();
    logic        is_ld, done, allow;
    logic [31:0] val, res;
    is_ld = m_bus[73];
    done  = m_valid && (!is_ld || m_got || data_sram_data_ok);
    val   = m_got ? m_data : data_sram_rdata;
    res   = is_ld ? ref_ext(m_bus[34:32], m_bus[33+:2] & 2'b00 | m_bus[36:35], val)
                  : m_bus[66:35];
    allow = !m_valid || (done && ws_allowin);
    chk("rnd_allowin", 74'(ms_allowin), 74'(allow));
    chk("rnd_valid", 74'(ms_to_ws_valid), 74'(done));
    if (done)
      chk("rnd_bus", 74'(ms_to_ws_bus),
          74'({m_bus[72], m_bus[71:67], res, m_bus[31:0]}));
    if (m_valid && is_ld && !m_got && data_sram_data_ok && !ws_allowin) begin
      m_got  = 1'b1;
      m_data = data_sram_rdata;
    end
    if (allow) begin
      m_valid = es_to_ms_valid;
      m_bus   = es_to_ms_bus;
      m_got   = 1'b0;
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 3'd0, 2'd0, 32'h0,         32'h0000_1234, 32'h0000_1234};
    vecs[1]  = '{1'b1, 3'd1, 2'd3, 32'h80FF_0000, 32'h1000_0003, 32'hFFFF_FF80};
    vecs[2]  = '{1'b1, 3'd1, 2'd0, 32'h0000_007F, 32'h1000_0000, 32'h0000_007F};
    vecs[3]  = '{1'b1, 3'd3, 2'd3, 32'h80FF_0000, 32'h1000_0003, 32'h0000_0080};
    vecs[4]  = '{1'b1, 3'd2, 2'd2, 32'h80FF_1234, 32'h1000_0002, 32'hFFFF_80FF};
    vecs[5]  = '{1'b1, 3'd2, 2'd0, 32'h80FF_1234, 32'h1000_0000, 32'h0000_1234};
    vecs[6]  = '{1'b1, 3'd4, 2'd2, 32'h80FF_1234, 32'h1000_0002, 32'h0000_80FF};
    vecs[7]  = '{1'b1, 3'd0, 2'd0, 32'hDEAD_BEEF, 32'h1000_0000, 32'hDEAD_BEEF};
    vecs[8]  = '{1'b1, 3'd5, 2'd0, 32'h1234_5678, 32'h1000_0000, 32'h1234_5678};
    vecs[9]  = '{1'b1, 3'd3, 2'd1, 32'h0000_A500, 32'h1000_0001, 32'h0000_00A5};
    vecs[10] = '{1'b1, 3'd1, 2'd1, 32'h0000_A500, 32'h1000_0001, 32'hFFFF_FFA5};
    vecs[11] = '{1'b1, 3'd2, 2'd0, 32'h0000_8001, 32'h1000_0000, 32'hFFFF_8001};

    resetn = 1'b0;
    idle_in();
    #3;
    chk("rst_allowin", 74'(ms_allowin), 74'd1);
    chk("rst_valid", 74'(ms_to_ws_valid), 74'd0);
    chk("rst_collect", 74'(ms_rf_collect), 74'd0);
    chk("rst_bus", 74'(ms_to_ws_bus), 74'd0);
    @(negedge clk);
    resetn = 1'b1;
    next_cyc();

    // table: issue, then data one cycle later with WB open
    for (int i = 0; i < 12; i++) begin
      es_to_ms_valid = 1'b1;
      es_to_ms_bus = mk_bus(vecs[i].ld, 1'b1, 5'd5, vecs[i].alu,
                            vecs[i].op, 32'h1C00_0000 + 32'(i * 4));
      next_cyc();
      es_to_ms_valid    = 1'b0;
      data_sram_data_ok = vecs[i].ld;
      data_sram_rdata   = vecs[i].rdata;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), 74'(ms_to_ws_valid), 74'd1);
      chk($sformatf("vec%0d_res", i), 74'(ms_to_ws_bus[63:32]),
          74'(vecs[i].exp));
      next_cyc();
      idle_in();
    end

    // ld.hu with data 3 cycles late
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_bus(1'b1, 1'b1, 5'd6, 32'h2000_0002, 3'd4, 32'h1C00_0100);
    next_cyc();
    es_to_ms_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("late_allowin", 74'(ms_allowin), 74'd0);
      chk("late_valid", 74'(ms_to_ws_valid), 74'd0);
      next_cyc();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h80FF_1234;
    @(negedge clk);
    chk("late_res", 74'(ms_to_ws_bus[63:32]), 74'h0000_80FF);
    chk("late_allowin1", 74'(ms_allowin), 74'd1);
    next_cyc();
    idle_in();

    // ld.w returns while WB stalled; rdata then changes
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_bus(1'b1, 1'b1, 5'd7, 32'h3000_0000, 3'd0, 32'h1C00_0200);
    next_cyc();
    es_to_ms_valid    = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1122_3344;
    ws_allowin        = 1'b0;
    @(negedge clk);
    chk("hold_allowin0", 74'(ms_allowin), 74'd0);
    next_cyc();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("hold_valid", 74'(ms_to_ws_valid), 74'd1);
    chk("hold_res", 74'(ms_to_ws_bus[63:32]), 74'h1122_3344);
    next_cyc();
    ws_allowin = 1'b1;
    @(negedge clk);
    chk("hold_out", 74'(ms_to_ws_bus[63:32]), 74'h1122_3344);
    chk("hold_allowin1", 74'(ms_allowin), 74'd1);
    next_cyc();
    idle_in();

    // reset while waiting, then a stray data_ok
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_bus(1'b1, 1'b1, 5'd8, 32'h4000_0000, 3'd0, 32'h1C00_0300);
    next_cyc();
    es_to_ms_valid = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    chk("wrst_valid", 74'(ms_to_ws_valid), 74'd0);
    chk("wrst_allowin", 74'(ms_allowin), 74'd1);
    chk("wrst_collect", 74'(ms_rf_collect), 74'd0);
    @(negedge clk);
    resetn = 1'b1;
    next_cyc();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h5555_AAAA;
    @(negedge clk);
    chk("stray_valid", 74'(ms_to_ws_valid), 74'd0);
    next_cyc();
    idle_in();
    @(negedge clk);
    chk("stray_valid2", 74'(ms_to_ws_valid), 74'd0);
    chk("stray_allowin", 74'(ms_allowin), 74'd1);
    next_cyc();

    // load then ALU op; ALU accepted as the load leaves
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_bus(1'b1, 1'b1, 5'd9, 32'h5000_0000, 3'd0, 32'h1C00_0400);
    next_cyc();
    es_to_ms_bus = mk_bus(1'b0, 1'b1, 5'd10, 32'h0000_0055, 3'd0, 32'h1C00_0404);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hCAFE_F00D;
    @(negedge clk);
    chk("seq_ld_bus", 74'(ms_to_ws_bus),
        74'({1'b1, 5'd9, 32'hCAFE_F00D, 32'h1C00_0400}));
    chk("seq_allowin", 74'(ms_allowin), 74'd1);
    next_cyc();
    idle_in();
    @(negedge clk);
    chk("seq_alu_valid", 74'(ms_to_ws_valid), 74'd1);
    chk("seq_alu_bus", 74'(ms_to_ws_bus),
        74'({1'b1, 5'd10, 32'h0000_0055, 32'h1C00_0404}));
    chk("seq_collect", 74'(ms_rf_collect),
        74'({1'b0, 1'b1, 5'd10, 32'h0000_0055}));
    next_cyc();

    // randomized traffic against the slot model
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
    m_valid = 1'b0;
    m_bus   = '0;
    m_got   = 1'b0;
    m_data  = '0;
    for (int c = 0; c < 3000; c++) begin
      es_to_ms_valid = ($urandom_range(0, 2) != 0);
      es_to_ms_bus = mk_bus(1'($urandom_range(0, 1)), 1'($urandom),
                            5'($urandom), $urandom,
                            3'($urandom_range(0, 7)), $urandom);
      data_sram_data_ok = ($urandom_range(0, 2) == 0);
      data_sram_rdata   = $urandom;
      ws_allowin        = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      model_step();
      next_cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
